update_pack_arbiter: RTL

Shares one 8-lane update packer (64-bit updates, 512-bit lines, prefix-valid masks) between NUM_REQ processing-element update streams. Round-robin arbitration picks one requester per cycle and forwards its partial line and mask to the packer. When every requester has declared end-of-stream, it issues the packer's single-cycle flush (`last_input_in`) and then reports completion. Sits between the PE scatter pipelines and the update-line packer in the scatter phase.

---
 rtl/upa_pkg.sv | 35 +++
 rtl/update_pack_arbiter_if.sv | 34 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/update_pack_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/upa_pkg.sv
// Shared types and helpers for the update-line packer arbiter.
package upa_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned LINE_W = LANES * WORD_W;
  localparam int unsigned MASK_W = LANES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [LINE_W-1:0] word;
    logic [MASK_W-1:0] mask;
  } line_t;

  // Legal masks are 1..8 ones packed against the MSB, zeros below.
  function automatic logic is_prefix_mask(input logic [MASK_W-1:0] m);
    logic [MASK_W-1:0] inv;
    inv = ~m;
    return (m != '0) && ((inv & (inv + MASK_W'(1))) == '0);
  endfunction

  function automatic logic [3:0] popcount8(input logic [MASK_W-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < int'(MASK_W); i++) c = c + 4'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/update_pack_arbiter_if.sv
// Requester-side and packer-side signal bundle for update_pack_arbiter.
interface update_pack_arbiter_if
  import upa_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 32
);

  logic                        start;
  logic [NUM_REQ*LINE_W-1:0]   req_word;
  logic [NUM_REQ*MASK_W-1:0]   req_valid;
  logic [NUM_REQ-1:0]          req_last;
  logic [NUM_REQ-1:0]          req_ready;
  logic [LINE_W-1:0]           pk_word_out;
  logic [MASK_W-1:0]           pk_valid_out;
  logic                        pk_last_out;
  logic [2:0]                  grant_id;
  logic [CNT_W-1:0]            update_count;
  logic                        done;
  logic                        err;

  modport slave (
    input  start, req_word, req_valid, req_last,
    output req_ready, pk_word_out, pk_valid_out, pk_last_out,
           grant_id, update_count, done, err
  );

  modport master (
    output start, req_word, req_valid, req_last,
    input  req_ready, pk_word_out, pk_valid_out, pk_last_out,
           grant_id, update_count, done, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; search starts one past the last grant.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant_c,
  output logic [PTR_W-1:0] grant_idx_c
);

  logic [PTR_W-1:0] ptr;
  logic             found;
  int unsigned      idx;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[PTR_W'(idx)]) begin
        found                 = 1'b1;
        grant_c[PTR_W'(idx)]  = 1'b1;
        grant_idx_c           = PTR_W'(idx);
      end
    end
  end

  // Pointer rests on the last granted index; reset value makes requester 0 first.
  always_ff @(posedge clk) begin
    if (rst || clear) ptr <= PTR_W'(N - 1);
    else if (advance) ptr <= grant_idx_c;
  end

endmodule

// File: rtl/update_pack_arbiter.sv
// Shares one update-line packer among NUM_REQ PE streams and issues the final flush.
// Optional UPA_MASK_CHECK_EN: drop non-prefix masks and raise a sticky err.
module update_pack_arbiter
  import upa_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 32
) (
  input logic clk,
  input logic rst,
  update_pack_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [NUM_REQ-1:0] has_req;
  logic [NUM_REQ-1:0] finished;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gidx;
  logic               accept;
  logic               start_ok;
  line_t              sel;

  always_comb begin
    has_req  = '0;
    finished = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      has_req[i]  = |bus.req_valid[i*int'(MASK_W) +: MASK_W];
      finished[i] = bus.req_last[i] & ~has_req[i];
    end
    cand     = (state == ST_RUN) ? has_req : '0;
    accept   = |grant;
    start_ok = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    sel.word = bus.req_word[int'(gidx)*int'(LINE_W) +: LINE_W];
    sel.mask = bus.req_valid[int'(gidx)*int'(MASK_W) +: MASK_W];
  end

  assign bus.req_ready = grant;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_ok),
    .advance     (accept),
    .req         (cand),
    .grant_c     (grant),
    .grant_idx_c (gidx)
  );

  // Phase FSM with registered packer-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      bus.pk_word_out  <= '0;
      bus.pk_valid_out <= '0;
      bus.pk_last_out  <= 1'b0;
      bus.grant_id     <= '0;
      bus.update_count <= '0;
      bus.done         <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      bus.pk_word_out  <= '0;
      bus.pk_valid_out <= '0;
      bus.pk_last_out  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state            <= ST_RUN;
            bus.update_count <= '0;
            bus.err          <= 1'b0;
            bus.done         <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            bus.grant_id <= 3'(gidx);
`ifdef UPA_MASK_CHECK_EN
            if (!is_prefix_mask(sel.mask)) begin
              bus.err <= 1'b1;
            end else begin
              bus.pk_word_out  <= sel.word;
              bus.pk_valid_out <= sel.mask;
              bus.update_count <= bus.update_count + CNT_W'(popcount8(sel.mask));
            end
`else
            bus.pk_word_out  <= sel.word;
            bus.pk_valid_out <= sel.mask;
            bus.update_count <= bus.update_count + CNT_W'(popcount8(sel.mask));
`endif
          end else if (&finished) begin
            state           <= ST_FLUSH;
            bus.pk_last_out <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state    <= ST_DONE;
          bus.done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
